ddr_cmd_issuer: RTL and testbench

- Controller-side stage that drives the DDR4 command/address pins feeding the DIMM model.
- Accepts one read/write request at a time: bank group, bank, row and column.
- Emits a legal ACT / RD / WR / PRE sequence with programmable spacing between commands.
- Pulses cas_done when the CAS goes out, so the data path can launch write data or arm read capture.

---
 rtl/ddr_pkg.sv | 54 +++++
 rtl/bank_row_table.sv | 47 ++++
 rtl/ddr_cmd_issuer.sv | 206 ++++++++++++++++++++
 tb/tb_ddr_cmd_issuer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR4 command issuer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr_pkg;

    localparam int ROW_W = 15;
    localparam int COL_W = 10;

    // Command pin field order: {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}.
    // ACT only fixes the first two pins; the rest carry row bits.
    localparam logic [1:0] CMD_ACT_PFX = 2'b00;
    localparam logic [4:0] CMD_WR      = 5'b01100;
    localparam logic [4:0] CMD_RD      = 5'b01101;
    localparam logic [4:0] CMD_PRE     = 5'b01010;
    localparam logic [4:0] CMD_NOP     = 5'b11111;

    typedef struct packed {
        logic             wr;
        logic [1:0]       bg;
        logic [1:0]       ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } ddr_req_t;

    // Everything that goes out on the command/address pins in one cycle.
    typedef struct packed {
        logic [4:0]       cmd;
        logic             a13;
        logic             a12;
        logic             a11;
        logic             a10;
        logic [COL_W-1:0] a9_0;
        logic [1:0]       bg;
        logic [1:0]       ba;
    } pin_bus_t;

    localparam pin_bus_t PINS_NOP = {CMD_NOP, 18'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_WAIT_GAP,
        S_PRE,
        S_WAIT_RP
    } state_e;

    // A timing value T is counted as the command cycle plus T-1 more.
    function automatic logic [3:0] cnt_init(input int unsigned t);
        return 4'(t - 1);
    endfunction

endpackage

// File: rtl/bank_row_table.sv
// Open-row tracker: one open flag plus row per {bg, ba}; only built with DDR_OPEN_PAGE_EN.
// Latency: lookup is combinational; set/clear take effect on the next clk_i edge.
// Backpressure: none; set and clear are single-cycle strobes.
// Ports: clk_i/rst_ni, lookup (lk_idx_i, lk_row_i -> lk_open_o, lk_hit_o),
//        set (set_vld_i, set_idx_i, set_row_i), clear (clr_vld_i, clr_idx_i).
`ifdef DDR_OPEN_PAGE_EN
module bank_row_table
    import ddr_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [3:0]       lk_idx_i,
    input  logic [ROW_W-1:0] lk_row_i,
    output logic             lk_open_o,
    output logic             lk_hit_o,
    input  logic             set_vld_i,
    input  logic [3:0]       set_idx_i,
    input  logic [ROW_W-1:0] set_row_i,
    input  logic             clr_vld_i,
    input  logic [3:0]       clr_idx_i
);

    logic [15:0]      open_q;
    logic [ROW_W-1:0] row_q [16];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_q <= '0;
            for (int i = 0; i < 16; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            if (set_vld_i) begin
                open_q[set_idx_i] <= 1'b1;
                row_q[set_idx_i]  <= set_row_i;
            end
            if (clr_vld_i) begin
                open_q[clr_idx_i] <= 1'b0;
            end
        end
    end

    assign lk_open_o = open_q[lk_idx_i];
    assign lk_hit_o  = open_q[lk_idx_i] && (row_q[lk_idx_i] == lk_row_i);

endmodule
`endif

// File: rtl/ddr_cmd_issuer.sv
// DDR4 command issuer: turns one read/write request into ACT/RD/WR/PRE on registered pins.
// Latency: first command one cycle after accept; CAS T_RCD after ACT (or right away on an open-page hit).
// Backpressure: req_ready only in IDLE; one request in flight at a time.
// Ports: CK_t/reset_n; request (req_valid/req_ready, req_wr, req_bg, req_ba, req_row, req_col);
//        command/address pins; cas_done/cas_is_wr strobe for the data path.
// Optional: DDR_OPEN_PAGE_EN keeps rows open and tracks them in bank_row_table.
module ddr_cmd_issuer
    import ddr_pkg::*;
#(
    parameter int unsigned T_RCD     = 4,
    parameter int unsigned T_RP      = 4,
    parameter int unsigned T_CAS_GAP = 4
) (
    input  logic             CK_t,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [1:0]       req_bg,
    input  logic [1:0]       req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    output logic             cs_n,
    output logic             act_n,
    output logic             RAS_n_A16,
    output logic             CAS_n_A15,
    output logic             WE_n_A14,
    output logic             A13,
    output logic             A12_BC_n,
    output logic             A11,
    output logic             A10_AP,
    output logic [COL_W-1:0] A9_A0,
    output logic [1:0]       bg_addr,
    output logic [1:0]       ba_addr,
    output logic             cas_done,
    output logic             cas_is_wr
);

`ifdef DDR_OPEN_PAGE_EN
    localparam logic AP_BIT = 1'b0;
`else
    localparam logic AP_BIT = 1'b1;
`endif

    state_e   state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ddr_req_t req_q, req_d, req_in;
    pin_bus_t pins_q, pins_d;
    logic     ready_q;
    logic     cas_done_q, cas_wr_q;
    logic     accept;

    assign req_in = {req_wr, req_bg, req_ba, req_row, req_col};
    // ready_q is low for the first cycle after reset even though the FSM is idle.
    assign accept = req_valid && ready_q;
    assign req_d  = accept ? req_in : req_q;

`ifdef DDR_OPEN_PAGE_EN
    logic lk_open, lk_hit;

    bank_row_table u_tbl (
        .clk_i     (CK_t),
        .rst_ni    (reset_n),
        .lk_idx_i  ({req_bg, req_ba}),
        .lk_row_i  (req_row),
        .lk_open_o (lk_open),
        .lk_hit_o  (lk_hit),
        .set_vld_i (state_q == S_ACT),
        .set_idx_i ({req_q.bg, req_q.ba}),
        .set_row_i (req_q.row),
        .clr_vld_i (state_q == S_PRE),
        .clr_idx_i ({req_q.bg, req_q.ba})
    );
`endif

    // Next state. The counter is loaded as a command goes out, so the command
    // cycle itself is the first cycle of the interval that follows it.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef DDR_OPEN_PAGE_EN
                    if (lk_hit) begin
                        state_d = S_CAS;
                        cnt_d   = cnt_init(T_CAS_GAP);
                    end else if (lk_open) begin
                        state_d = S_PRE;
                        cnt_d   = cnt_init(T_RP);
                    end else begin
                        state_d = S_ACT;
                        cnt_d   = cnt_init(T_RCD);
                    end
`else
                    state_d = S_ACT;
                    cnt_d   = cnt_init(T_RCD);
`endif
                end
            end
            S_ACT, S_WAIT_RCD: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAS;
                    cnt_d   = cnt_init(T_CAS_GAP);
                end else begin
                    state_d = S_WAIT_RCD;
                end
            end
            S_CAS, S_WAIT_GAP: begin
                if (cnt_q == 4'd0) begin
`ifdef DDR_OPEN_PAGE_EN
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
`else
                    // Auto-precharge starts here; tRP is counted from this point.
                    state_d = S_WAIT_RP;
                    cnt_d   = cnt_init(T_RP);
`endif
                end else begin
                    state_d = S_WAIT_GAP;
                end
            end
            S_PRE, S_WAIT_RP: begin
                if (cnt_q == 4'd0) begin
`ifdef DDR_OPEN_PAGE_EN
                    // Only a page miss precharges; the request still needs its ACT.
                    state_d = S_ACT;
                    cnt_d   = cnt_init(T_RCD);
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    state_d = S_WAIT_RP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pin encode from the next state so that every pin leaves a flop.
    always_comb begin
        pins_d = PINS_NOP;
        unique case (state_d)
            S_ACT: begin
                pins_d.cmd  = {CMD_ACT_PFX, 2'b00, req_d.row[14]};
                pins_d.a13  = req_d.row[13];
                pins_d.a12  = req_d.row[12];
                pins_d.a11  = req_d.row[11];
                pins_d.a10  = req_d.row[10];
                pins_d.a9_0 = req_d.row[9:0];
                pins_d.bg   = req_d.bg;
                pins_d.ba   = req_d.ba;
            end
            S_CAS: begin
                pins_d.cmd  = req_d.wr ? CMD_WR : CMD_RD;
                pins_d.a12  = 1'b1;  // BL8 only, never burst-chop
                pins_d.a10  = AP_BIT;
                pins_d.a9_0 = req_d.col;
                pins_d.bg   = req_d.bg;
                pins_d.ba   = req_d.ba;
            end
            S_PRE: begin
                pins_d.cmd = CMD_PRE;
                pins_d.bg  = req_d.bg;
                pins_d.ba  = req_d.ba;
            end
            default: pins_d = PINS_NOP;
        endcase
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            req_q      <= '0;
            pins_q     <= PINS_NOP;
            ready_q    <= 1'b0;
            cas_done_q <= 1'b0;
            cas_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            pins_q     <= pins_d;
            ready_q    <= (state_d == S_IDLE);
            cas_done_q <= (state_d == S_CAS);
            cas_wr_q   <= (state_d == S_CAS) && req_d.wr;
        end
    end

    assign req_ready = ready_q;
    assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = pins_q.cmd;
    assign A13       = pins_q.a13;
    assign A12_BC_n  = pins_q.a12;
    assign A11       = pins_q.a11;
    assign A10_AP    = pins_q.a10;
    assign A9_A0     = pins_q.a9_0;
    assign bg_addr   = pins_q.bg;
    assign ba_addr   = pins_q.ba;
    assign cas_done  = cas_done_q;
    assign cas_is_wr = cas_wr_q;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Bench for ddr_cmd_issuer: directed and random requests against a per-cycle expected pin trace.
// Latency: n/a.
// Backpressure: holds req_valid until the modelled accept cycle.
module tb_ddr_cmd_issuer;

    localparam int RCD = 4;
    localparam int RP  = 3;
    localparam int GAP = 4;
    localparam int N   = 4096;
    localparam logic [22:0] NOP = {5'b11111, 18'b0};

    logic        CK_t    = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr  = 1'b0;
    logic [1:0]  req_bg  = 2'd0;
    logic [1:0]  req_ba  = 2'd0;
    logic [14:0] req_row = 15'd0;
    logic [9:0]  req_col = 10'd0;
    logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic        A13, A12_BC_n, A11, A10_AP;
    logic [9:0]  A9_A0;
    logic [1:0]  bg_addr, ba_addr;
    logic        cas_done, cas_is_wr;
    logic [22:0] pins_obs;

    always #5 CK_t = ~CK_t;

    ddr_cmd_issuer #(.T_RCD(RCD), .T_RP(RP), .T_CAS_GAP(GAP)) dut (
        .CK_t(CK_t), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15),
        .WE_n_A14(WE_n_A14), .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11),
        .A10_AP(A10_AP), .A9_A0(A9_A0), .bg_addr(bg_addr), .ba_addr(ba_addr),
        .cas_done(cas_done), .cas_is_wr(cas_is_wr)
    );

    assign pins_obs = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
                       A13, A12_BC_n, A11, A10_AP, A9_A0, bg_addr, ba_addr};

    // Expected trace, indexed by cycle number (cycle n follows posedge n).
    logic [22:0] exp_pins [N];
    bit          exp_rdy  [N];
    bit          exp_cas  [N];
    bit          exp_cwr  [N];
    int          cyc, free_cyc, checks, failures;
`ifdef DDR_OPEN_PAGE_EN
    bit          mdl_open [16];
    logic [14:0] mdl_row  [16];
`endif

    function automatic logic [22:0] act_p(input logic [1:0] bg, ba, input logic [14:0] row);
        return {4'b0000, row, bg, ba};
    endfunction

    function automatic logic [22:0] cas_p(input logic wr, input logic [1:0] bg, ba,
                                          input logic [9:0] col);
`ifdef DDR_OPEN_PAGE_EN
        return {(wr ? 5'b01100 : 5'b01101), 1'b0, 1'b1, 1'b0, 1'b0, col, bg, ba};
`else
        return {(wr ? 5'b01100 : 5'b01101), 1'b0, 1'b1, 1'b0, 1'b1, col, bg, ba};
`endif
    endfunction

    function automatic logic [22:0] pre_p(input logic [1:0] bg, ba);
        return {5'b01010, 14'b0, bg, ba};
    endfunction

    task automatic chk_pins(input string tag, input logic [22:0] obs, input logic [22:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic clear_from(input int from, input int rdy_from);
        for (int i = from; i < N; i++) begin
            exp_pins[i] = NOP;
            exp_rdy[i]  = (i >= rdy_from);
            exp_cas[i]  = 1'b0;
            exp_cwr[i]  = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CK_t);
        cyc++;
        if (cyc >= N - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, N - 1);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge CK_t);
        chk_pins("pins", pins_obs, exp_pins[cyc]);
        chk_bit("req_ready", req_ready, exp_rdy[cyc]);
        chk_bit("cas_done", cas_done, exp_cas[cyc]);
        chk_bit("cas_is_wr", cas_is_wr, exp_cwr[cyc]);
    endtask

    // Schedule one request in the model, then drive it until the accept edge.
    task automatic issue(input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                         input logic [14:0] row, input logic [9:0] col, input int lead);
        int a, c, nf;
`ifdef DDR_OPEN_PAGE_EN
        int t;
        logic [3:0] idx;
`endif
        repeat (lead) tick();
        req_valid = 1'b1;
        req_wr = wr; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
        a = (cyc > free_cyc) ? cyc : free_cyc;
`ifdef DDR_OPEN_PAGE_EN
        idx = {bg, ba};
        if (mdl_open[idx] && mdl_row[idx] == row) begin
            c = a + 1;
        end else begin
            t = a + 1;
            if (mdl_open[idx]) begin
                exp_pins[t] = pre_p(bg, ba);
                t = t + RP;
            end
            exp_pins[t] = act_p(bg, ba, row);
            c = t + RCD;
            mdl_open[idx] = 1'b1;
            mdl_row[idx]  = row;
        end
        nf = c + GAP;
`else
        exp_pins[a + 1] = act_p(bg, ba, row);
        c  = a + 1 + RCD;
        nf = c + GAP + RP;
`endif
        exp_pins[c] = cas_p(wr, bg, ba, col);
        exp_cas[c]  = 1'b1;
        exp_cwr[c]  = wr;
        for (int i = a + 1; i < nf; i++) exp_rdy[i] = 1'b0;
        free_cyc = nf;
        while (cyc < a + 1) tick();
        req_valid = 1'b0;
        req_wr = 1'($urandom); req_bg = 2'($urandom); req_ba = 2'($urandom);
        req_row = 15'($urandom); req_col = 10'($urandom);
    endtask

    task automatic reset_pulse(input int hold);
        reset_n = 1'b0;
        #1;
        chk_pins("rst_async_pins", pins_obs, NOP);
        chk_bit("rst_async_ready", req_ready, 1'b0);
        chk_bit("rst_async_cas", cas_done, 1'b0);
        clear_from(cyc + 1, N);
        repeat (hold) tick();
        reset_n = 1'b1;
        clear_from(cyc + 1, cyc + 1);
        free_cyc = cyc + 1;
`ifdef DDR_OPEN_PAGE_EN
        for (int i = 0; i < 16; i++) mdl_open[i] = 1'b0;
`endif
    endtask

    initial begin
        cyc = 0; checks = 0; failures = 0; free_cyc = 0;
        clear_from(0, N);
        #2;
        reset_pulse(3);

        // Directed write with the documented address pattern.
        issue(1'b1, 2'd1, 2'd2, 15'h4ABC, 10'h1F0, 1);
        // Back-to-back reads to one bank; the second waits for tCAS_GAP + tRP.
        issue(1'b0, 2'd3, 2'd0, 15'h1234, 10'h055, 0);
        issue(1'b0, 2'd3, 2'd0, 15'h1234, 10'h2AA, 0);
        // Long idle stretch: NOP pins with ready high.
        while (cyc < free_cyc + 20) tick();
        // Reset one cycle after ACT: the in-flight request must vanish.
        issue(1'b1, 2'd2, 2'd1, 15'h7FFF, 10'h3FF, 2);
        tick();
        reset_pulse(2);
        repeat (3) tick();

`ifdef DDR_OPEN_PAGE_EN
        // Hit then miss on one bank.
        issue(1'b0, 2'd2, 2'd1, 15'h0010, 10'h001, 1);
        issue(1'b0, 2'd2, 2'd1, 15'h0010, 10'h002, 0);
        issue(1'b0, 2'd2, 2'd1, 15'h0020, 10'h003, 0);
        // Open every bank, reset, then bank 0 needs a fresh ACT.
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 2'(i >> 2), 2'(i), 15'($urandom), 10'($urandom), 0);
        end
        while (cyc < free_cyc + 1) tick();
        reset_pulse(2);
        issue(1'b0, 2'd0, 2'd0, 15'h0010, 10'h010, 1);
`endif

        // Random traffic, biased towards a few rows and banks so pages get reused.
        for (int k = 0; k < 40; k++) begin
            logic [14:0] r;
            case ($urandom_range(0, 2))
                0:       r = 15'h0010;
                1:       r = 15'h0020;
                default: r = 15'($urandom);
            endcase
            issue(1'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
                  r, 10'($urandom), $urandom_range(0, 6));
        end
        while (cyc < free_cyc + 5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
